// File: rtl/store_buffer_if.sv
// Bundles the signals between the core's data port, the store buffer and the backing data memory.
// The slave modport is the store buffer's view; the master modport is the core/memory side's view.
interface store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] DataMemAddr;
  logic          DataMemRead;
  logic          DataMemWrite;
  logic [DW-1:0] DataMemWData;
  logic [DW-1:0] DataMemRData;
  logic          Stall;
  logic          Empty;
  logic [AW-1:0] MemRAddr;
  logic [DW-1:0] MemRData;
  logic          MemWrite;
  logic [AW-1:0] MemWAddr;
  logic [DW-1:0] MemWData;
  logic          MemWReady;

  modport slave (
    input  DataMemAddr, DataMemRead, DataMemWrite, DataMemWData, MemRData, MemWReady,
    output DataMemRData, Stall, Empty, MemRAddr, MemWrite, MemWAddr, MemWData
  );

  modport master (
    output DataMemAddr, DataMemRead, DataMemWrite, DataMemWData, MemRData, MemWReady,
    input  DataMemRData, Stall, Empty, MemRAddr, MemWrite, MemWAddr, MemWData
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between the core data port and data memory, with store-to-load forwarding.
// Optional STORE_BUF_STATS_EN adds saturating StallCnt/FwdCnt event counters.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  store_buffer_if.slave         bus
`ifdef STORE_BUF_STATS_EN
  ,
  output logic [31:0]           StallCnt,
  output logic [31:0]           FwdCnt
`endif
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        entry_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          stall;
  logic          push;
  logic          pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  // Flow control depends only on registered count and current core/memory handshake inputs.
  assign full  = (count_q == CW'(DEPTH));
  assign stall = bus.DataMemWrite & full & ~bus.MemWReady;
  assign push  = bus.DataMemWrite & ~stall;
  assign pop   = (count_q != '0) & bus.MemWReady;

  assign bus.Stall    = stall;
  assign bus.Empty    = (count_q == '0);
  assign bus.MemWrite = (count_q != '0);
  assign bus.MemWAddr = entry_q[head_q].addr;
  assign bus.MemWData = entry_q[head_q].data;
  assign bus.MemRAddr = bus.DataMemAddr;

  // Walk oldest to youngest so the youngest matching entry wins; the popping head still counts.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (entry_q[PW'(head_q + PW'(i))].addr == bus.DataMemAddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_q[PW'(head_q + PW'(i))].data;
      end
    end
  end

  always_comb begin
    bus.DataMemRData = '0;
    if (bus.DataMemRead) begin
      bus.DataMemRData = fwd_hit ? fwd_data : bus.MemRData;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = PW'(tail_q + PW'(1));
    end
    if (pop) begin
      head_d = PW'(head_q + PW'(1));
    end
    count_d = CW'(count_q + CW'(push) - CW'(pop));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally left uncleared by reset; validity comes from count.
  always_ff @(posedge CLK) begin
    if (push) begin
      entry_q[tail_q] <= '{addr: bus.DataMemAddr, data: bus.DataMemWData};
    end
  end

`ifdef STORE_BUF_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bus.DataMemRead && fwd_hit && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FwdCnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain, fill/stall, forwarding, hazards, reset, program.
// Backing memory is modelled as an associative array updated on every accepted drain write.
module tb_store_buffer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   wr_cnt;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

`ifdef STORE_BUF_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
`ifdef STORE_BUF_STATS_EN
    ,
    .StallCnt (stall_cnt),
    .FwdCnt   (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Records any drain accepted at the coming edge, then advances to just after it.
  task automatic tick();
    #1;
    if (bus.MemWrite && bus.MemWReady) begin
      mem_model[bus.MemWAddr] = bus.MemWData;
      wr_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_core();
    bus.DataMemWrite = 1'b0;
    bus.DataMemRead  = 1'b0;
    bus.DataMemAddr  = '0;
    bus.DataMemWData = '0;
  endtask

  task automatic drain_all(input string tag);
    int budget;
    budget = 0;
    bus.MemWReady = 1'b1;
    #1;
    while (!bus.Empty && budget < 50) begin
      tick();
      budget++;
    end
    check({tag, "_drained"}, 32'(bus.Empty), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_drain [4];
    int budget;
    n_checks = 0;
    n_errors = 0;
    wr_cnt   = 0;
    rst_n    = 1'b0;
    idle_core();
    bus.MemRData  = '0;
    bus.MemWReady = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_empty", 32'(bus.Empty), 32'd1);
    check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst_stall", 32'(bus.Stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single store drains one cycle later
    bus.MemWReady    = 1'b1;
    bus.DataMemWrite = 1'b1;
    bus.DataMemAddr  = 32'h10;
    bus.DataMemWData = 32'd7;
    #1;
    check("single_stall", 32'(bus.Stall), 32'd0);
    check("single_no_writethrough", 32'(bus.MemWrite), 32'd0);
    tick();
    idle_core();
    #1;
    check("single_memwrite", 32'(bus.MemWrite), 32'd1);
    check("single_waddr", bus.MemWAddr, 32'h10);
    check("single_wdata", bus.MemWData, 32'd7);
    tick();
    check("single_empty", 32'(bus.Empty), 32'd1);
    check("single_mem", mem_model[32'h10], 32'd7);

    // Fill while memory is not ready, then stall and same-edge accept on pop
    bus.MemWReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.DataMemWrite = 1'b1;
      bus.DataMemAddr  = 32'(16 * i);
      bus.DataMemWData = 32'(i + 2);
      #1;
      check($sformatf("fill_stall%0d", i), 32'(bus.Stall), 32'd0);
      tick();
    end
    bus.DataMemAddr  = 32'd64;
    bus.DataMemWData = 32'd6;
    #1;
    check("full_stall", 32'(bus.Stall), 32'd1);
    check("full_head_addr", bus.MemWAddr, 32'd0);
    tick();
    check("full_stall_held", 32'(bus.Stall), 32'd1);
    check("full_head_data", bus.MemWData, 32'd2);
    bus.MemWReady = 1'b1;
    #1;
    check("full_accept_on_pop", 32'(bus.Stall), 32'd0);
    tick();
    idle_core();
    exp_drain = '{32'd3, 32'd4, 32'd5, 32'd6};
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("drain_order%0d", k), bus.MemWData, exp_drain[k]);
      tick();
    end
    check("fill_empty", 32'(bus.Empty), 32'd1);
    check("fill_mem64", mem_model[32'd64], 32'd6);

    // Forwarding picks the youngest match; misses fall through to memory
    bus.MemWReady    = 1'b0;
    bus.DataMemWrite = 1'b1;
    bus.DataMemAddr  = 32'h20;
    bus.DataMemWData = 32'd9;
    tick();
    bus.DataMemWData = 32'd11;
    tick();
    idle_core();
    bus.DataMemRead = 1'b1;
    bus.DataMemAddr = 32'h20;
    bus.MemRData    = 32'd0;
    #1;
    check("fwd_youngest", bus.DataMemRData, 32'd11);
    bus.DataMemAddr = 32'h24;
    bus.MemRData    = 32'h0000_ABCD;
    #1;
    check("fwd_miss", bus.DataMemRData, 32'h0000_ABCD);
    bus.DataMemRead = 1'b0;
    #1;
    check("no_read_zero", bus.DataMemRData, 32'd0);
    // Popping head stays visible: store 0x40=1 behind, drain down to the 0x40 entry alone
    bus.DataMemWrite = 1'b1;
    bus.DataMemAddr  = 32'h40;
    bus.DataMemWData = 32'd1;
    tick();
    idle_core();
    bus.MemWReady = 1'b1;
    tick();
    tick();
    bus.DataMemRead = 1'b1;
    bus.DataMemAddr = 32'h40;
    bus.MemRData    = 32'd77;
    #1;
    check("fwd_popping_head", bus.DataMemRData, 32'd1);
    tick();
    check("fwd_after_pop", bus.DataMemRData, 32'd77);
    idle_core();
    drain_all("fwd");

    // Same-cycle load/store to one address returns the prior value
    bus.MemWReady    = 1'b0;
    bus.MemRData     = 32'd1;
    bus.DataMemRead  = 1'b1;
    bus.DataMemWrite = 1'b1;
    bus.DataMemAddr  = 32'h30;
    bus.DataMemWData = 32'd5;
    #1;
    check("hazard_same_cycle", bus.DataMemRData, 32'd1);
    tick();
    bus.DataMemWrite = 1'b0;
    #1;
    check("hazard_next_cycle", bus.DataMemRData, 32'd5);
    idle_core();
    drain_all("hazard");

    // Asynchronous reset mid-drain discards everything
    bus.MemWReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.DataMemWrite = 1'b1;
      bus.DataMemAddr  = 32'(32'h100 + 4 * i);
      bus.DataMemWData = 32'(i + 1);
      tick();
    end
    idle_core();
    check("prerst_memwrite", 32'(bus.MemWrite), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("async_rst_empty", 32'(bus.Empty), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wr_cnt = 0;
    bus.MemWReady = 1'b1;
    repeat (4) tick();
    check("rst_no_writes", 32'(wr_cnt), 32'd0);
    check("rst_still_empty", 32'(bus.Empty), 32'd1);

    // Program: for i<3, j<4: D[16*j] = i+j with random memory readiness
    mem_model.delete();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        bus.DataMemWrite = 1'b1;
        bus.DataMemAddr  = 32'(16 * j);
        bus.DataMemWData = 32'(i + j);
        budget = 0;
        forever begin
          bus.MemWReady = 1'($urandom_range(0, 1));
          #1;
          if (!bus.Stall) begin
            tick();
            break;
          end
          tick();
          budget++;
          if (budget > 200) begin
            check("prog_stall_timeout", 32'd1, 32'd0);
            break;
          end
        end
      end
    end
    idle_core();
    drain_all("prog");
    for (int j = 0; j < 4; j++) begin
      check($sformatf("prog_mem%0d", 16 * j),
            mem_model.exists(32'(16 * j)) ? mem_model[32'(16 * j)] : 32'hDEAD_BEEF,
            32'(2 + j));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the RISCV core's data-memory port (DataMemAddr/Read/Write/WData/RData) and the backing data memory.
- Accepts core stores into a small in-order FIFO and returns with no added latency.
- Drains stores to memory through a ready/valid write port.
- Forwards buffered data to loads (store-to-load forwarding) so the core always reads the newest value.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width; addresses compared exactly, no byte masking.
- DW, 32, data width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- DataMemAddr  in  AW  core load/store address.
- DataMemRead  in  1  core load request.
- DataMemWrite  in  1  core store request.
- DataMemWData  in  DW  core store data.
- DataMemRData  out  DW  load data to core, combinational.
- Stall  out  1  store cannot be accepted this cycle; core must hold the request.
- Empty  out  1  buffer holds no entries.
- MemRAddr  out  AW  backing-memory read address, equal to DataMemAddr.
- MemRData  in  DW  backing-memory read data, combinational.
- MemWrite  out  1  head entry valid for drain.
- MemWAddr  out  AW  head entry address.
- MemWData  out  DW  head entry data.
- MemWReady  in  1  memory accepts the head entry at this edge.

Behaviour:
- State: DEPTH entries {addr, data}, head/tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset (RST=0, async): count=0, pointers=0, Stall=0, Empty=1, MemWrite=0. Entry storage is not cleared. Reset mid-drain discards all entries; no partial write is issued after reset.
- push = DataMemWrite & ~Stall.
- pop = MemWrite & MemWReady.
- MemWrite = (count!=0); MemWAddr/MemWData come from the head entry, registered state only.
- Stall = DataMemWrite & (count==DEPTH) & ~MemWReady.
  - A store arriving while full is accepted when a pop occurs in the same cycle.
- At the rising edge:
  - push writes the entry at tail, tail+1.
  - pop advances head, head+1.
  - count += push - pop.
  - Push and pop together leave count unchanged.
- Empty = (count==0). A store is never written straight through, even when empty: it appears on MemWrite one cycle later.
- Load forwarding (DataMemRead=1): search valid entries youngest to oldest; first exact DataMemAddr match supplies DataMemRData, else DataMemRData = MemRData.
  - The head entry being popped this cycle is still valid for forwarding.
  - A store to the same address in the same cycle is not visible; the load returns the prior value.
- DataMemRead=0: DataMemRData = 0.
- Same-cycle DataMemRead and DataMemWrite is legal; they are handled independently.
- Order is strictly FIFO. Multiple entries with the same address are all drained in order; there is no coalescing.
- Stall, Empty and MemWrite are functions of registered state plus current inputs only, with no combinational path from MemRData.

Optional Feature:
- Macro STORE_BUF_STATS_EN.
- Defined: adds outputs StallCnt[31:0] and FwdCnt[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - StallCnt increments each cycle Stall=1.
  - FwdCnt increments each cycle a load is served from the buffer.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single store, MemWReady=1: write addr 0x10 data 7 -> Stall=0, next cycle MemWrite=1 MemWAddr=0x10 MemWData=7, following cycle Empty=1.
- Fill while MemWReady=0: four stores addr 0,16,32,48 data 2,3,4,5 -> count=4, fifth store sees Stall=1. Raise MemWReady -> fifth accepted that same edge; drain order 2,3,4,5 then the fifth.
- Forwarding: MemWReady=0, store addr 0x20=9, then addr 0x20=11; load 0x20 with MemRData=0 -> DataMemRData=11 (youngest). Load 0x24 -> MemRData.
- Same-cycle hazard: buffer empty, MemRData=1, load and store to addr 0x30 data 5 together -> DataMemRData=1; next-cycle load of 0x30 -> 5.
- Reset mid-drain: 3 entries, MemWReady=0, pulse RST low -> MemWrite=0 and Empty=1 immediately; no writes after release.
- Core program i<3, j<4, D[16*j]=i+j run with random MemWReady -> final memory at 0,16,32,48 = 2,3,4,5; Empty=1 at end.
